// File: rtl/lpddr2_seq_dbg_cmd_arbiter.sv
// rtl/lpddr2_seq_dbg_cmd_arbiter.sv - two-requester debug command arbiter onto the sequencer mailbox
module lpddr2_seq_dbg_cmd_arbiter #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] CMD_BASE    = 'h15240,
  parameter int unsigned       PARAM_WORDS = 2,
  parameter int unsigned       POLL_GAP    = 8,
  parameter int unsigned       MAX_POLLS   = 1024
) (
  input  logic                            avl_clk,
  input  logic                            avl_reset_n,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic [2*DATA_W-1:0]             req_cmd,
  input  logic [2*PARAM_WORDS*DATA_W-1:0] req_param,
  output logic [1:0]                      rsp_valid,
  output logic [DATA_W-1:0]               rsp_status,
  output logic                            rsp_timeout,
  output logic                            busy,
  output logic [ADDR_W-1:0]               m_address,
  output logic                            m_write,
  output logic                            m_read,
  output logic [DATA_W-1:0]               m_writedata,
  input  logic                            m_waitrequest,
  input  logic [DATA_W-1:0]               m_readdata,
  input  logic                            m_readdatavalid
);

  localparam int PCW   = $clog2(MAX_POLLS + 1);
  localparam int GCW   = $clog2(POLL_GAP + 1);
  localparam int WIW   = (PARAM_WORDS > 1) ? $clog2(PARAM_WORDS) : 1;
  localparam int PBITS = PARAM_WORDS * DATA_W;

  typedef enum logic [2:0] {
    IDLE, WR_PARAM, WR_CMD, POLL_WAIT, RD_REQ, RD_WAIT, CLR, RESP
  } state_t;

  state_t            state, state_nx;
  logic              last_grant, owner, grant, grant_sel, done;
  logic [DATA_W-1:0] cmd_q, status_q;
  logic [PBITS-1:0]  param_q;
  logic [WIW-1:0]    widx;
  logic [GCW-1:0]    gap_cnt;
  logic [PCW-1:0]    poll_cnt, poll_inc;
  logic              timeout_q;

  // Reset gates the grant so req_ready stays low while the block is held in reset.
  assign grant     = (state == IDLE) && (|req_valid) && avl_reset_n;
  assign grant_sel = (&req_valid) ? ~last_grant : req_valid[1];
  assign poll_inc  = poll_cnt + 1'b1;
  assign done      = m_readdata[DATA_W-1];

  assign rsp_status  = status_q;
  assign rsp_timeout = (state == RESP) && timeout_q;
  assign busy        = (state != IDLE) || grant;

  always_comb begin
    state_nx    = state;
    req_ready   = '0;
    rsp_valid   = '0;
    m_write     = 1'b0;
    m_read      = 1'b0;
    m_address   = '0;
    m_writedata = '0;
    case (state)
      IDLE: begin
        if (grant) begin
          req_ready[grant_sel] = 1'b1;
          state_nx             = WR_PARAM;
        end
      end
      WR_PARAM: begin
        m_write   = 1'b1;
        m_address = CMD_BASE + ADDR_W'(8) + ADDR_W'({widx, 2'b00});
        for (int k = 0; k < int'(PARAM_WORDS); k++) begin
          if (widx == WIW'(k)) m_writedata = param_q[k*DATA_W +: DATA_W];
        end
        if (!m_waitrequest && widx == WIW'(PARAM_WORDS - 1)) state_nx = WR_CMD;
      end
      WR_CMD: begin
        m_write     = 1'b1;
        m_address   = CMD_BASE;
        m_writedata = cmd_q;
        if (!m_waitrequest) state_nx = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (gap_cnt <= GCW'(1)) state_nx = RD_REQ;
      end
      RD_REQ: begin
        m_read    = 1'b1;
        m_address = CMD_BASE + ADDR_W'(4);
        if (!m_waitrequest) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (m_readdatavalid) begin
          if (done)                           state_nx = CLR;
          else if (poll_inc == PCW'(MAX_POLLS)) state_nx = RESP;
          else                                state_nx = POLL_WAIT;
        end
      end
      CLR: begin
        m_write   = 1'b1;
        m_address = CMD_BASE + ADDR_W'(4);
        if (!m_waitrequest) state_nx = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        state_nx         = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cmd_q      <= '0;
      param_q    <= '0;
      widx       <= '0;
      gap_cnt    <= '0;
      poll_cnt   <= '0;
      status_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant) begin
            owner      <= grant_sel;
            last_grant <= grant_sel;
            cmd_q      <= grant_sel ? req_cmd[DATA_W +: DATA_W] : req_cmd[0 +: DATA_W];
            param_q    <= grant_sel ? req_param[PBITS +: PBITS] : req_param[0 +: PBITS];
            widx       <= '0;
            poll_cnt   <= '0;
            timeout_q  <= 1'b0;
          end
        end
        WR_PARAM:  if (!m_waitrequest) widx <= widx + 1'b1;
        WR_CMD:    gap_cnt <= GCW'(POLL_GAP);
        POLL_WAIT: gap_cnt <= gap_cnt - 1'b1;
        RD_WAIT: begin
          if (m_readdatavalid) begin
            status_q <= m_readdata;
            poll_cnt <= poll_inc;
            gap_cnt  <= GCW'(POLL_GAP);
            if (!done && poll_inc == PCW'(MAX_POLLS)) timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpddr2_seq_dbg_cmd_arbiter.sv
// tb/tb_lpddr2_seq_dbg_cmd_arbiter.sv - directed bench with an Avalon slave model for the debug command arbiter
module tb_lpddr2_seq_dbg_cmd_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [63:0]  req_cmd = '0;
  logic [127:0] req_param = '0;
  logic [1:0]   rsp_valid;
  logic [31:0]  rsp_status;
  logic         rsp_timeout, busy;
  logic [31:0]  m_address, m_writedata;
  logic         m_write, m_read;
  logic         m_waitrequest = 1'b0;
  logic [31:0]  m_readdata = '0;
  logic         m_readdatavalid = 1'b0;

  lpddr2_seq_dbg_cmd_arbiter #(
    .ADDR_W(32), .DATA_W(32), .CMD_BASE(32'h15240),
    .PARAM_WORDS(2), .POLL_GAP(8), .MAX_POLLS(4)
  ) dut (
    .avl_clk(clk), .avl_reset_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_param(req_param),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_address(m_address), .m_write(m_write), .m_read(m_read), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  int          max_wait = 0, lat_max = 1, done_at = 1, poll_base = 0;
  logic [31:0] done_word = '0, nd_word = '0;

  int          n_log = 0, n_rdv = 0, poll_num = 0, stab_err = 0;
  logic [64:0] log_ent [0:127];
  int          log_cyc [0:127];
  int          rdv_cyc [0:127];
  int          stall_left = 0, rd_cnt = 0;
  logic        in_xfer = 1'b0, rd_pending = 1'b0;
  logic [66:0] snap = '0;
  logic [31:0] rd_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_xfer = 1'b0; rd_pending = 1'b0; m_readdatavalid = 1'b0; m_waitrequest = 1'b0;
    end else begin
      m_readdatavalid = 1'b0;
      if (rd_pending) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          m_readdatavalid = 1'b1; m_readdata = rd_data; rd_pending = 1'b0;
          if (n_rdv < 128) rdv_cyc[n_rdv] = cyc;
          n_rdv++;
        end
      end
      if (m_write && m_read) stab_err++;
      if (m_write || m_read) begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          snap = {m_write, m_read, m_address, m_writedata};
          stall_left = (max_wait == 0) ? 0 : int'($urandom_range(max_wait, 0));
        end else if ({m_write, m_read, m_address, m_writedata} !== snap) begin
          stab_err++;
        end
        if (stall_left > 0) begin
          m_waitrequest = 1'b1; stall_left--;
        end else begin
          m_waitrequest = 1'b0; in_xfer = 1'b0;
          if (n_log < 128) begin
            log_ent[n_log] = {m_write, m_address, m_writedata};
            log_cyc[n_log] = cyc;
          end
          n_log++;
          if (m_read) begin
            poll_num++;
            rd_data = (poll_num - poll_base >= done_at) ? done_word : nd_word;
            rd_cnt = (lat_max <= 1) ? 1 : int'($urandom_range(lat_max, 1));
            rd_pending = 1'b1;
          end
        end
      end else begin
        if (in_xfer) stab_err++;
        in_xfer = 1'b0; m_waitrequest = 1'b0;
      end
    end
  end

  int          n_grant = 0, n_rsp = 0;
  logic [1:0]  g_bits [0:31];
  int          g_cyc  [0:31];
  logic [1:0]  r_bits [0:31];
  logic [31:0] r_status [0:31];
  logic        r_to [0:31];
  logic        r_busy [0:31];
  int          r_cyc [0:31];

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != 2'b00) begin
        if (n_grant < 32) begin g_bits[n_grant] = req_ready; g_cyc[n_grant] = cyc; end
        n_grant++;
      end
      if (rsp_valid != 2'b00) begin
        if (n_rsp < 32) begin
          r_bits[n_rsp] = rsp_valid; r_status[n_rsp] = rsp_status;
          r_to[n_rsp] = rsp_timeout; r_busy[n_rsp] = busy; r_cyc[n_rsp] = cyc;
        end
        n_rsp++;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int prev);
    int guard = 0;
    while (n_grant == prev && guard < 400) begin @(posedge clk); #1; guard++; end
    check("grant_wait", 128'(n_grant != prev), 128'(1));
  endtask

  task automatic wait_rsp(input int prev);
    int guard = 0;
    while (n_rsp == prev && guard < 400) begin @(posedge clk); #1; guard++; end
    check("rsp_wait", 128'(n_rsp != prev), 128'(1));
  endtask

  function automatic logic [64:0] ent(input logic we, input logic [31:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [64:0] exp_log [0:7];
  int lb, gb, rb, db, G;

  initial begin
    #1;
    check("reset_outputs",
          128'({req_ready, rsp_valid, rsp_status, rsp_timeout, busy, m_address, m_write, m_read, m_writedata}),
          128'(0));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single command from requester 0, done on the third poll
    poll_base = poll_num; done_at = 3; done_word = 32'h8000_0003; nd_word = 32'h0;
    max_wait = 0; lat_max = 1;
    lb = n_log; gb = n_grant; rb = n_rsp; db = n_rdv;
    @(posedge clk); #1;
    req_cmd[31:0] = 32'h5; req_param[31:0] = 32'hA; req_param[63:32] = 32'hB; req_valid = 2'b01;
    wait_grant(gb);
    req_valid = 2'b00; req_cmd = {2{32'hDEAD_BEEF}}; req_param = {4{32'hFFFF_FFFF}};
    wait_rsp(rb);
    check("t1_idle_busy", 128'({busy, m_write, m_read}), 128'(0));
    exp_log[0] = ent(1'b1, 32'h15248, 32'hA);
    exp_log[1] = ent(1'b1, 32'h1524C, 32'hB);
    exp_log[2] = ent(1'b1, 32'h15240, 32'h5);
    exp_log[3] = ent(1'b0, 32'h15244, 32'h0);
    exp_log[4] = ent(1'b0, 32'h15244, 32'h0);
    exp_log[5] = ent(1'b0, 32'h15244, 32'h0);
    exp_log[6] = ent(1'b1, 32'h15244, 32'h0);
    check("t1_xfer_count", 128'(n_log - lb), 128'(7));
    for (int i = 0; i < 7; i++) check($sformatf("t1_xfer%0d", i), 128'(log_ent[lb+i]), 128'(exp_log[i]));
    G = g_cyc[gb];
    check("t1_grant_bits", 128'(g_bits[gb]), 128'(2'b01));
    check("t1_lat_param0", 128'(log_cyc[lb] - G), 128'(1));
    check("t1_lat_opcode", 128'(log_cyc[lb+2] - G), 128'(3));
    check("t1_lat_read1", 128'(log_cyc[lb+3] - G), 128'(12));
    check("t1_poll_gap", 128'(log_cyc[lb+4] - rdv_cyc[db]), 128'(9));
    check("t1_lat_clear", 128'(log_cyc[lb+6] - log_cyc[lb+5]), 128'(2));
    check("t1_lat_rsp", 128'(r_cyc[rb] - log_cyc[lb+5]), 128'(3));
    check("t1_rsp_bits", 128'(r_bits[rb]), 128'(2'b01));
    check("t1_rsp_status", 128'(r_status[rb]), 128'(32'h8000_0003));
    check("t1_rsp_timeout", 128'(r_to[rb]), 128'(0));
    check("t1_rsp_busy", 128'(r_busy[rb]), 128'(1));

    // Timeout from requester 1: status never done, MAX_POLLS=4
    poll_base = poll_num; done_at = 1000; nd_word = 32'h1;
    lb = n_log; gb = n_grant; rb = n_rsp;
    req_cmd[63:32] = 32'h7; req_param[95:64] = 32'h1; req_param[127:96] = 32'h2; req_valid = 2'b10;
    wait_grant(gb);
    req_valid = 2'b00;
    wait_rsp(rb);
    repeat (20) @(posedge clk); #1;
    check("to_xfer_count", 128'(n_log - lb), 128'(7));
    check("to_opcode", 128'(log_ent[lb+2]), 128'(ent(1'b1, 32'h15240, 32'h7)));
    for (int i = 3; i < 7; i++) check($sformatf("to_read%0d", i - 3), 128'(log_ent[lb+i]), 128'(ent(1'b0, 32'h15244, 32'h0)));
    check("to_rsp_bits", 128'(r_bits[rb]), 128'(2'b10));
    check("to_rsp_status", 128'(r_status[rb]), 128'(32'h1));
    check("to_rsp_timeout", 128'(r_to[rb]), 128'(1));

    // Reset while the command sits in POLL_WAIT
    poll_base = poll_num; done_at = 1; done_word = 32'h8000_0042;
    lb = n_log; gb = n_grant; rb = n_rsp;
    req_cmd[31:0] = 32'h9; req_valid = 2'b01;
    wait_grant(gb);
    req_valid = 2'b00;
    repeat (5) @(posedge clk); #1;
    check("rst_busy_before", 128'(busy), 128'(1));
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          128'({req_ready, rsp_valid, rsp_status, rsp_timeout, busy, m_address, m_write, m_read, m_writedata}),
          128'(0));
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("rst_no_more_xfers", 128'(n_log - lb), 128'(3));
    check("rst_no_rsp", 128'(n_rsp - rb), 128'(0));

    // Simultaneous requests after reset: grants 0,1,0
    poll_base = poll_num;
    lb = n_log; gb = n_grant; rb = n_rsp;
    req_cmd = {32'h20, 32'h10};
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_grant(gb + k);
      if (k == 2) req_valid[0] = 1'b0;
      if (g_bits[gb+k] == 2'b10) req_valid[1] = 1'b0;
      wait_rsp(rb + k);
    end
    req_valid = 2'b00;
    check("rr_grant0", 128'(g_bits[gb]), 128'(2'b01));
    check("rr_grant1", 128'(g_bits[gb+1]), 128'(2'b10));
    check("rr_grant2", 128'(g_bits[gb+2]), 128'(2'b01));
    check("rr_rsp0", 128'(r_bits[rb]), 128'(2'b01));
    check("rr_rsp1", 128'(r_bits[rb+1]), 128'(2'b10));
    check("rr_rsp2", 128'(r_bits[rb+2]), 128'(2'b01));
    check("rr_opcode0", 128'(log_ent[lb+2]), 128'(ent(1'b1, 32'h15240, 32'h10)));
    check("rr_opcode1", 128'(log_ent[lb+7]), 128'(ent(1'b1, 32'h15240, 32'h20)));
    check("rr_opcode2", 128'(log_ent[lb+12]), 128'(ent(1'b1, 32'h15240, 32'h10)));
    check("rr_next_grant", 128'(g_cyc[gb+1] - r_cyc[rb]), 128'(1));
    check("rr_status1", 128'(r_status[rb+1]), 128'(32'h8000_0042));

    // Waitrequest and read-latency stress from requester 1
    @(posedge clk); #1;
    poll_base = poll_num; done_at = 2; done_word = 32'h8000_00AB; nd_word = 32'h0;
    max_wait = 5; lat_max = 7;
    lb = n_log; gb = n_grant; rb = n_rsp;
    req_cmd[63:32] = 32'h33; req_param[95:64] = 32'h44; req_param[127:96] = 32'h55; req_valid = 2'b10;
    wait_grant(gb);
    req_valid = 2'b00;
    wait_rsp(rb);
    exp_log[0] = ent(1'b1, 32'h15248, 32'h44);
    exp_log[1] = ent(1'b1, 32'h1524C, 32'h55);
    exp_log[2] = ent(1'b1, 32'h15240, 32'h33);
    exp_log[3] = ent(1'b0, 32'h15244, 32'h0);
    exp_log[4] = ent(1'b0, 32'h15244, 32'h0);
    exp_log[5] = ent(1'b1, 32'h15244, 32'h0);
    check("st_xfer_count", 128'(n_log - lb), 128'(6));
    for (int i = 0; i < 6; i++) check($sformatf("st_xfer%0d", i), 128'(log_ent[lb+i]), 128'(exp_log[i]));
    check("st_rsp_bits", 128'(r_bits[rb]), 128'(2'b10));
    check("st_rsp_status", 128'(r_status[rb]), 128'(32'h8000_00AB));
    check("st_rsp_timeout", 128'(r_to[rb]), 128'(0));
    check("avalon_stability", 128'(stab_err), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lpddr2_seq_dbg_cmd_arbiter.md
# lpddr2_seq_dbg_cmd_arbiter

Arbitrates debug commands from two requesters (JTAG debug master = 0, user CSR bridge = 1) onto the LPDDR2 sequencer core-debug command mailbox through a single Avalon-MM master. For each granted command it writes the parameter words to `SEQ_CORE_CMD_PARAMS` and the opcode to `SEQ_CORE_REQ_CMD`. It then polls `SEQ_CORE_CMD_STATUS` until the sequencer reports done or a poll limit expires, clears the status word, and returns the result to the originating requester. It sits between the debug fabric and the sequencer's Avalon slave, and is the only writer of the command mailbox.

## Interface
Parameters:
- `ADDR_W`, 32: Avalon byte-address width.
- `DATA_W`, 32: data width; fixed at 32 for this mailbox.
- `CMD_BASE`, 'h15240: address of `SEQ_CORE_REQ_CMD`. `CMD_STATUS` is `CMD_BASE+4`; parameter words start at `CMD_BASE+8`.
- `PARAM_WORDS`, 2: number of parameter words written per command (1..4).
- `POLL_GAP`, 8: idle cycles between status reads (≥1).
- `MAX_POLLS`, 1024: number of status reads before timeout (≥1).

Ports:
- `avl_clk`, in, 1: single clock.
- `avl_reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 2: per-requester request; held until accepted.
- `req_ready`, out, 2: one-cycle accept pulse; bit i = requester i.
- `req_cmd`, in, 2*DATA_W: opcode, requester i in bits `[i*DATA_W +: DATA_W]`.
- `req_param`, in, 2*PARAM_WORDS*DATA_W: requester i, word k at `[(i*PARAM_WORDS+k)*DATA_W +: DATA_W]`.
- `rsp_valid`, out, 2: one-cycle completion pulse to the owning requester.
- `rsp_status`, out, DATA_W: last status word read; valid with `rsp_valid`.
- `rsp_timeout`, out, 1: set with `rsp_valid` when `MAX_POLLS` was exhausted.
- `busy`, out, 1: high from grant until `rsp_valid`, inclusive.
- `m_address`, out, ADDR_W: Avalon address.
- `m_write`, out, 1: Avalon write strobe.
- `m_read`, out, 1: Avalon read strobe.
- `m_writedata`, out, DATA_W: Avalon write data.
- `m_waitrequest`, in, 1: Avalon stall.
- `m_readdata`, in, DATA_W: Avalon read data.
- `m_readdatavalid`, in, 1: Avalon read-data qualifier.

## Operation
- **State machine:** IDLE → WR_PARAM → WR_CMD → POLL_WAIT → RD_REQ → RD_WAIT → (CLR | POLL_WAIT | RESP); CLR → RESP → IDLE.
- **IDLE:**
  - Any `req_valid` selects requester g and pulses `req_ready[g]`.
  - Opcode and parameters are latched on the same edge, so the requester may change its inputs after the pulse.
- **Arbitration:** round-robin.
  - If both requesters are valid, grant the one not granted last.
  - After reset, requester 0 wins a tie.
  - A requester that is not granted keeps `req_valid` high and is not dropped.
- **WR_PARAM:** write word k to `CMD_BASE+8+4k` for k = 0..PARAM_WORDS-1, in order.
- **WR_CMD:** write the opcode to `CMD_BASE`, then load the gap counter with `POLL_GAP`.
- **POLL_WAIT:** count down to 0, then go to RD_REQ.
- **RD_REQ:** assert `m_read` at `CMD_BASE+4`. Exactly one read is outstanding at a time.
- **RD_WAIT:** on `m_readdatavalid`, capture `m_readdata` and increment the poll count. Then:
  - `status[31]`=1 (done) → CLR.
  - Otherwise, poll count = `MAX_POLLS` → RESP with timeout set.
  - Otherwise → POLL_WAIT.
- **CLR:** write 0 to `CMD_BASE+4` to acknowledge. A timed-out command skips CLR so the sequencer state is preserved for debug.
- **RESP:** pulse `rsp_valid[g]` and drive `rsp_status` and `rsp_timeout`, then return to IDLE.
- **Avalon rules:**
  - `m_write`/`m_read` and their address and data are held stable while `m_waitrequest`=1.
  - A transfer completes on the cycle the strobe is high and `m_waitrequest`=0.
  - `m_write` and `m_read` are never both high.
- **Counters:**
  - Poll count is `clog2(MAX_POLLS+1)` bits wide and cleared on grant.
  - The gap counter is reloaded on every entry to POLL_WAIT.

## Timing
- **Reset values:** all outputs 0, state IDLE, last-grant = 1 (so requester 0 wins first).
- **Reset mid-command:** abandons it immediately. No status clear and no response are issued, and any outstanding read data is ignored.
- **Minimum latency** (waitrequest=0, readdatavalid one cycle after the read is accepted, done on the first poll):
  - grant at cycle 0;
  - first parameter write at cycle 1;
  - opcode write at cycle `1+PARAM_WORDS`;
  - read at `2+PARAM_WORDS+POLL_GAP`;
  - clear two cycles later;
  - `rsp_valid` on the next cycle.
- **Next grant:** the earliest next `req_ready` is the cycle after `rsp_valid`. IDLE lasts at least one cycle.
- **Stalls:** each `m_waitrequest` cycle adds exactly one cycle. `m_readdatavalid` may arrive any number of cycles after the read is accepted.
- **Ignored inputs:** `m_readdatavalid` outside RD_WAIT is ignored.

## Test plan
- **Single command:** requester 0 sends opcode 'h5, params {'hA,'hB}; the model returns status 'h8000_0003 on the 3rd poll. Required:
  - writes 'hA @'h15248, 'hB @'h1524C, 'h5 @'h15240;
  - three reads @'h15244, then a write of 0 @'h15244;
  - `rsp_valid`=2'b01, `rsp_status`='h8000_0003, `rsp_timeout`=0.
- **Simultaneous requests after reset:** both raised for 3 back-to-back commands → grants go 0, 1, 0; each `rsp_valid` bit matches its grant; requests are never lost.
- **Timeout:** `MAX_POLLS`=4, status stays 'h0000_0001 → exactly 4 reads, no clear write, `rsp_timeout`=1, `rsp_status`='h1.
- **Waitrequest stress:** random 0–5 cycle `m_waitrequest` and 1–7 cycle readdatavalid latency → address and data stay stable while stalled, the transaction order is unchanged, and the response is correct.
- **Reset mid-poll:** assert `avl_reset_n`=0 in POLL_WAIT → all outputs 0 asynchronously. After release, a new command runs cleanly with requester 0 priority.
- **Gap timing:** `POLL_GAP`=8 with status not done → exactly 8 idle cycles between the readdatavalid of one poll and the `m_read` of the next.
